bcd_addsub_seq_ctrl: RTL and testbench
======================================

Name: bcd_addsub_seq_ctrl

Overview:
- Sequencing controller for the 3-digit (12-bit) BCD add/subtract datapath.
- Accepts an operand pair and an opcode, then compares magnitudes via the existing 12-bit BCD comparator (L/E/G outputs).
- For subtraction, orders the operands as larger minus smaller and sets the sign.
- Runs one BCD digit per clock, LSD first. Returns a sign-magnitude BCD result with done/overflow/invalid flags.

Parameters:
- CMP_STAGE, 1, 1 = comparator outputs registered in a dedicated CMP state; 0 = comparison used combinationally in the capture cycle, saving one cycle.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset
- start  input  1  request; accepted only when ready=1
- op  input  1  0 = A+B, 1 = A-B
- a  input  12  operand A, three BCD digits [11:8][7:4][3:0]
- b  input  12  operand B, same format
- abort  input  1  present only with BCD_ADDSUB_ABORT_EN
- ready  output  1  high in IDLE
- busy  output  1  high in CMP and DIGIT states
- done  output  1  one-cycle pulse, result valid
- result  output  12  BCD magnitude
- sign  output  1  1 = negative result
- overflow  output  1  add carry out of digit 2
- invalid  output  1  an input digit was >9

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. rst dominates all other inputs.
- Reset values: state=IDLE, ready=1, busy=0, done=0, result=000, sign=0, overflow=0, invalid=0.
- Reset mid-operation: aborts the operation, no done pulse, all outputs take reset values.
- States: IDLE, CMP (only when CMP_STAGE=1), DIGIT, DONE.
- IDLE:
  - start=1 latches a, b, op.
  - Any nibble >9 in a or b: go to DONE with invalid=1, result=000, sign=0, overflow=0.
  - Otherwise go to CMP, or to DIGIT when CMP_STAGE=0.
- CMP: register L/E/G and go to DIGIT.
- Operand ordering:
  - op=0: X=A, Y=B, sign=0.
  - op=1 with L=1 (A<B): X=B, Y=A, sign=1.
  - op=1 otherwise: X=A, Y=B, sign=0.
- DIGIT uses a 2-bit digit index 0..2 and a carry register.
  - Initial carry: 0 for add, 1 for subtract.
  - Add digit: s=X[i]+Y[i]+c. If s>9, digit=s+6 (low 4 bits) and c=1; else digit=s and c=0.
  - Subtract digit: same, with Y[i] replaced by 9-Y[i] (nine's complement).
  - After index 2, go to DONE.
  - overflow = final carry for add; 0 for subtract (the final subtract carry is discarded).
- Latency: start edge to done high = 5 edges with CMP_STAGE=1, 4 edges with CMP_STAGE=0.
- DONE:
  - result/sign/overflow/invalid are updated on entry to DONE.
  - done=1 for exactly one cycle, ready=0, then unconditional return to IDLE.
- Zero result: sign is forced to 0 (no negative zero), e.g. A-B with A=B.
- start while not in IDLE is ignored, with no queuing. Holding start high causes back-to-back operations, each accepted in IDLE.
- Output hold: all result outputs hold their values until the next DONE entry or reset. a and b may change after acceptance without effect.

Optional Feature:
- Macro: BCD_ADDSUB_ABORT_EN.
- Defined:
  - Adds the abort input.
  - abort=1 in CMP or DIGIT returns to IDLE on the next edge with no done pulse; result, sign, overflow and invalid keep their previous values.
  - abort in IDLE or DONE has no effect. rst still has priority over abort.
- Undefined: no abort port; every accepted operation runs to DONE.

Test Plan:
- Reset, then start, op=0, a=0x123, b=0x456 -> done exactly 5 edges after the start edge, result=0x579, sign=0, overflow=0; ready low from accept until return to IDLE.
- op=0, a=0x999, b=0x001 -> result=0x000, overflow=1, sign=0. Then op=0, a=0x058, b=0x067 -> result=0x125 (digit carries propagate).
- op=1, a=0x100, b=0x250 -> result=0x150, sign=1. Then op=1, a=0x250, b=0x100 -> result=0x150, sign=0. Then op=1, a=0x347, b=0x347 -> result=0x000, sign=0.
- op=0, a=0x1A3, b=0x001 -> DONE reached without DIGIT cycles, invalid=1, result=0x000. A second start pulse during a busy operation -> ignored, exactly one done.
- rst asserted during DIGIT index 1 -> next cycle all outputs at reset values, no done. Repeat with CMP_STAGE=0 -> latency 4 edges, same results as the first scenario.
- With BCD_ADDSUB_ABORT_EN: a completed result 0x579, then start op=1 a=0x500 b=0x001 and abort in DIGIT -> ready=1 next cycle, no done, result stays 0x579.

Source files
------------

// File: rtl/bcd_addsub_seq_ctrl.sv
// Sequencing controller for a 3-digit BCD add/subtract, one digit per clock, LSD first.
// Optional abort input enabled by defining BCD_ADDSUB_ABORT_EN.
module bcd_addsub_seq_ctrl #(
    parameter int CMP_STAGE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op,
    input  logic [11:0] a,
    input  logic [11:0] b,
`ifdef BCD_ADDSUB_ABORT_EN
    input  logic        abort,
`endif
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [11:0] result,
    output logic        sign,
    output logic        overflow,
    output logic        invalid
);

    typedef enum logic [1:0] {IDLE, CMP, DIGIT, DONE} state_t;

    state_t      state, state_next;
    logic [11:0] x_q, y_q;
    logic        op_q, lt_q, eq_q, carry_q;
    logic [1:0]  idx_q;
    logic [7:0]  acc_q;

    logic [11:0] cmp_a, cmp_b;
    logic        lt, eq, bad_in, abort_req, swap_in;
    logic [3:0]  dig;
    logic        c_next;
    logic [11:0] final_val;

    function automatic logic bad_bcd(input logic [11:0] v);
        return (v[3:0] > 4'd9) || (v[7:4] > 4'd9) || (v[11:8] > 4'd9);
    endfunction

    function automatic logic [3:0] nib(input logic [11:0] v, input logic [1:0] i);
        case (i)
            2'd0:    return v[3:0];
            2'd1:    return v[7:4];
            default: return v[11:8];
        endcase
    endfunction

    // Returns {carry_out, digit}; subtraction adds the nine's complement of y.
    function automatic logic [4:0] digit_add(input logic [3:0] x, input logic [3:0] y,
                                             input logic c, input logic sub);
        logic [3:0] ye;
        logic [4:0] s;
        ye = sub ? (4'd9 - y) : y;
        s  = {1'b0, x} + {1'b0, ye} + {4'd0, c};
        if (s > 5'd9)
            return {1'b1, s[3:0] + 4'd6};
        return {1'b0, s[3:0]};
    endfunction

`ifdef BCD_ADDSUB_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Magnitude comparator: latched operands when staged, raw inputs otherwise.
    assign cmp_a   = (CMP_STAGE != 0) ? x_q : a;
    assign cmp_b   = (CMP_STAGE != 0) ? y_q : b;
    assign lt      = cmp_a < cmp_b;
    assign eq      = cmp_a == cmp_b;
    assign swap_in = op && lt;
    assign bad_in  = bad_bcd(a) || bad_bcd(b);

    assign {c_next, dig} = digit_add(nib(x_q, idx_q), nib(y_q, idx_q), carry_q, op_q);
    assign final_val     = {dig, acc_q};

    assign ready = (state == IDLE);
    assign busy  = (state == CMP) || (state == DIGIT);
    assign done  = (state == DONE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (bad_in)
                        state_next = DONE;
                    else if (CMP_STAGE != 0)
                        state_next = CMP;
                    else
                        state_next = DIGIT;
                end
            end
            CMP: begin
                if (abort_req)
                    state_next = IDLE;
                else
                    state_next = DIGIT;
            end
            DIGIT: begin
                if (abort_req)
                    state_next = IDLE;
                else if (idx_q == 2'd2)
                    state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            result   <= 12'h000;
            sign     <= 1'b0;
            overflow <= 1'b0;
            invalid  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && start && bad_in) begin
                result   <= 12'h000;
                sign     <= 1'b0;
                overflow <= 1'b0;
                invalid  <= 1'b1;
            end else if (state == DIGIT && state_next == DONE) begin
                result   <= final_val;
                sign     <= op_q && lt_q && !eq_q && (final_val != 12'h000);
                overflow <= !op_q && c_next;
                invalid  <= 1'b0;
            end
        end
    end

    // Datapath registers carry no reset; the state machine qualifies them.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (start && !bad_in) begin
                    op_q    <= op;
                    carry_q <= op;
                    idx_q   <= 2'd0;
                    if (CMP_STAGE != 0) begin
                        x_q <= a;
                        y_q <= b;
                    end else begin
                        lt_q <= lt;
                        eq_q <= eq;
                        x_q  <= swap_in ? b : a;
                        y_q  <= swap_in ? a : b;
                    end
                end
            end
            CMP: begin
                lt_q <= lt;
                eq_q <= eq;
                if (op_q && lt) begin
                    x_q <= y_q;
                    y_q <= x_q;
                end
            end
            DIGIT: begin
                carry_q <= c_next;
                idx_q   <= idx_q + 2'd1;
                if (idx_q == 2'd0)
                    acc_q[3:0] <= dig;
                else if (idx_q == 2'd1)
                    acc_q[7:4] <= dig;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bcd_addsub_seq_ctrl.sv
// Scoreboard bench: two instances (staged and unstaged comparator) share stimulus;
// expected results are queued at issue and popped by a monitor on each done pulse.
module tb_bcd_addsub_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, op;
    logic [11:0] a, b;
`ifdef BCD_ADDSUB_ABORT_EN
    logic        abort;
`endif

    logic        ready1, busy1, done1, sign1, ovf1, inv1;
    logic [11:0] res1;
    logic        ready0, busy0, done0, sign0, ovf0, inv0;
    logic [11:0] res0;

    logic [14:0] exp_q1[$];
    logic [14:0] exp_q0[$];

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    bcd_addsub_seq_ctrl #(.CMP_STAGE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
`ifdef BCD_ADDSUB_ABORT_EN
        .abort(abort),
`endif
        .ready(ready1), .busy(busy1), .done(done1), .result(res1),
        .sign(sign1), .overflow(ovf1), .invalid(inv1)
    );

    bcd_addsub_seq_ctrl #(.CMP_STAGE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
`ifdef BCD_ADDSUB_ABORT_EN
        .abort(abort),
`endif
        .ready(ready0), .busy(busy0), .done(done0), .result(res0),
        .sign(sign0), .overflow(ovf0), .invalid(inv0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        logic [14:0] e;
        if (done1) begin
            if (exp_q1.size() == 0) begin
                check("unexpected_done_s1", 32'd1, 32'd0);
            end else begin
                e = exp_q1.pop_front();
                check("result_s1", {20'd0, res1}, {20'd0, e[14:3]});
                check("sign_s1", {31'd0, sign1}, {31'd0, e[2]});
                check("overflow_s1", {31'd0, ovf1}, {31'd0, e[1]});
                check("invalid_s1", {31'd0, inv1}, {31'd0, e[0]});
            end
        end
        if (done0) begin
            if (exp_q0.size() == 0) begin
                check("unexpected_done_s0", 32'd1, 32'd0);
            end else begin
                e = exp_q0.pop_front();
                check("result_s0", {20'd0, res0}, {20'd0, e[14:3]});
                check("sign_s0", {31'd0, sign0}, {31'd0, e[2]});
                check("overflow_s0", {31'd0, ovf0}, {31'd0, e[1]});
                check("invalid_s0", {31'd0, inv0}, {31'd0, e[0]});
            end
        end
    end

    task automatic check_reset_vals();
        check("rst_ready_s1", {31'd0, ready1}, 32'd1);
        check("rst_busy_s1", {31'd0, busy1}, 32'd0);
        check("rst_done_s1", {31'd0, done1}, 32'd0);
        check("rst_result_s1", {20'd0, res1}, 32'd0);
        check("rst_flags_s1", {29'd0, sign1, ovf1, inv1}, 32'd0);
        check("rst_ready_s0", {31'd0, ready0}, 32'd1);
        check("rst_busy_s0", {31'd0, busy0}, 32'd0);
        check("rst_done_s0", {31'd0, done0}, 32'd0);
        check("rst_result_s0", {20'd0, res0}, 32'd0);
        check("rst_flags_s0", {29'd0, sign0, ovf0, inv0}, 32'd0);
    endtask

    // Issue one operation; edges are counted with the accepting edge as edge 1.
    task automatic run_op(input logic o, input logic [11:0] va, input logic [11:0] vb,
                          input logic [11:0] er, input logic es, input logic eo,
                          input logic ei, input logic extra);
        int edges, lat1, lat0, exp1, exp0;
        exp_q1.push_back({er, es, eo, ei});
        exp_q0.push_back({er, es, eo, ei});
        exp1 = ei ? 1 : 5;
        exp0 = ei ? 1 : 4;
        @(negedge clk);
        op = o; a = va; b = vb; start = 1'b1;
        @(posedge clk);
        edges = 1; lat1 = -1; lat0 = -1;
        @(negedge clk);
        start = 1'b0;
        a = 12'hFFF; b = 12'h5A5;
        check("accept_ready_s1", {31'd0, ready1}, 32'd0);
        check("accept_ready_s0", {31'd0, ready0}, 32'd0);
        while ((lat1 < 0 || lat0 < 0) && edges < 20) begin
            if (done1 && lat1 < 0) lat1 = edges;
            if (done0 && lat0 < 0) lat0 = edges;
            start = (extra && edges == 2) ? 1'b1 : 1'b0;
            if (lat1 < 0 || lat0 < 0) begin
                @(posedge clk);
                edges++;
                @(negedge clk);
            end
        end
        start = 1'b0;
        check("latency_s1", lat1, exp1);
        check("latency_s0", lat0, exp0);
        @(posedge clk);
        @(negedge clk);
        check("back_ready_s1", {31'd0, ready1}, 32'd1);
        check("back_ready_s0", {31'd0, ready0}, 32'd1);
        check("hold_result_s1", {20'd0, res1}, {20'd0, er});
        check("hold_result_s0", {20'd0, res0}, {20'd0, er});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; op = 1'b0; a = 12'h000; b = 12'h000;
`ifdef BCD_ADDSUB_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals();
        rst = 1'b0;

        run_op(1'b0, 12'h123, 12'h456, 12'h579, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(1'b0, 12'h999, 12'h001, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op(1'b0, 12'h058, 12'h067, 12'h125, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(1'b1, 12'h100, 12'h250, 12'h150, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op(1'b1, 12'h250, 12'h100, 12'h150, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(1'b1, 12'h347, 12'h347, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(1'b0, 12'h1A3, 12'h001, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op(1'b0, 12'h123, 12'h456, 12'h579, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset while the staged instance is at digit index 1; no done may follow.
        @(negedge clk);
        op = 1'b0; a = 12'h123; b = 12'h456; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_busy_s1", {31'd0, busy1}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
        repeat (10) @(negedge clk);

`ifdef BCD_ADDSUB_ABORT_EN
        run_op(1'b0, 12'h123, 12'h456, 12'h579, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        op = 1'b1; a = 12'h500; b = 12'h001; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        check("abort_ready_s1", {31'd0, ready1}, 32'd1);
        check("abort_ready_s0", {31'd0, ready0}, 32'd1);
        check("abort_result_s1", {20'd0, res1}, 32'h579);
        check("abort_result_s0", {20'd0, res0}, 32'h579);
        repeat (10) @(negedge clk);
`endif

        check("queue_drain", exp_q1.size() + exp_q0.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
